dual_read_ram: RTL

DUAL_READ_RAM -- requirements
Module: dual_read_ram

---
 rtl/dual_read_ram.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dual_read_ram.sv
// Byte-addressed word RAM with one write port and two independent registered read ports.
// Optional zero-fill sequence after reset; bad addresses answer with an error pulse.
module dual_read_ram #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 1024,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   output logic                    o_ready,
   input  logic                    i_read_req,
   input  logic [ADDR_WIDTH-1:0]   i_read_addr,
   output logic [DATA_WIDTH-1:0]   o_read_data,
   output logic                    o_read_valid,
   output logic                    o_read_err,
   input  logic                    i_fetch_req,
   input  logic [ADDR_WIDTH-1:0]   i_fetch_addr,
   output logic [DATA_WIDTH-1:0]   o_fetch_data,
   output logic                    o_fetch_valid,
   output logic                    o_fetch_err,
   input  logic                    i_write_enable,
   input  logic [DATA_WIDTH/8-1:0] i_byte_enable,
   input  logic [ADDR_WIDTH-1:0]   i_write_addr,
   input  logic [DATA_WIDTH-1:0]   i_write_data,
   output logic                    o_write_err
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int LB = $clog2(NB);
   localparam int IW = $clog2(DEPTH);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   typedef struct packed {
      logic          bad;
      logic [IW-1:0] idx;
   } dec_t;

   function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] a);
      dec_t                  d;
      logic [ADDR_WIDTH-1:0] w;
      w     = a >> LB;
      d.idx = w[IW-1:0];
      d.bad = ((a & ADDR_WIDTH'(NB - 1)) != '0) || (w >= ADDR_WIDTH'(DEPTH));
      return d;
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   state_t                state, state_nxt;
   logic [IW-1:0]         clr_cnt;
   dec_t                  rd_dec, fe_dec, wr_dec;
   logic                  rd_acc, fe_acc, wr_acc;
   logic [DATA_WIDTH-1:0] rd_word, fe_word;

   assign rd_dec = decode(i_read_addr);
   assign fe_dec = decode(i_fetch_addr);
   assign wr_dec = decode(i_write_addr);
   assign rd_acc = o_ready && i_read_req;
   assign fe_acc = o_ready && i_fetch_req;
   assign wr_acc = o_ready && i_write_enable && !wr_dec.bad;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_nxt = state;
      if (state == ST_CLEAR && clr_cnt == IW'(DEPTH - 1))
         state_nxt = ST_READY;
   end

   // Write-first: enabled lanes of a same-edge write to the same word override the stored bytes.
   always_comb begin
      rd_word = mem[rd_dec.idx];
      fe_word = mem[fe_dec.idx];
      for (int l = 0; l < NB; l++) begin
         if (wr_acc && i_byte_enable[l]) begin
            if (rd_dec.idx == wr_dec.idx) rd_word[8*l +: 8] = i_write_data[8*l +: 8];
            if (fe_dec.idx == wr_dec.idx) fe_word[8*l +: 8] = i_write_data[8*l +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_cnt       <= '0;
         o_ready       <= 1'b0;
         o_read_data   <= '0;
         o_read_valid  <= 1'b0;
         o_read_err    <= 1'b0;
         o_fetch_data  <= '0;
         o_fetch_valid <= 1'b0;
         o_fetch_err   <= 1'b0;
         o_write_err   <= 1'b0;
      end else if (clk_en) begin
         state   <= state_nxt;
         o_ready <= (state_nxt == ST_READY);
         if (state == ST_CLEAR)
            clr_cnt <= clr_cnt + IW'(1);
         o_read_valid  <= rd_acc;
         o_read_err    <= rd_acc && rd_dec.bad;
         if (rd_acc)
            o_read_data <= rd_dec.bad ? '0 : rd_word;
         o_fetch_valid <= fe_acc;
         o_fetch_err   <= fe_acc && fe_dec.bad;
         if (fe_acc)
            o_fetch_data <= fe_dec.bad ? '0 : fe_word;
         o_write_err   <= o_ready && i_write_enable && wr_dec.bad;
      end
   end

   // NOTE: the array itself has no reset branch; zeroing is done word by word in the clear state.
   always_ff @(posedge clk) begin
      if (!rst && clk_en) begin
         if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
         end else if (wr_acc) begin
            for (int l = 0; l < NB; l++)
               if (i_byte_enable[l]) mem[wr_dec.idx][8*l +: 8] <= i_write_data[8*l +: 8];
         end
      end
   end

endmodule
